// File: rtl/adder_subtractor_16_bit_reg_pkg.sv
// adder_subtractor_16_bit_reg_pkg: shared ALU mode encodings
package adder_subtractor_16_bit_reg_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/adder_subtractor_16_bit_reg_full_adder_8_bit.sv
// adder_subtractor_16_bit_reg_full_adder_8_bit: 8-bit ripple adder built from XOR/AND/OR gates
module adder_subtractor_16_bit_reg_full_adder_8_bit (
  output logic [7:0] sum,
  output logic       cout,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin
);
  logic [8:0] c;
  logic [7:0] t, g, p;
  assign c[0] = cin;
  assign cout = c[8];
  for (genvar i = 0; i < 8; i++) begin : g_bit
    xor x0 (t[i], a[i], b[i]);
    xor x1 (sum[i], t[i], c[i]);
    and a0 (g[i], a[i], b[i]);
    and a1 (p[i], t[i], c[i]);
    or  o0 (c[i+1], g[i], p[i]);
  end
endmodule

// File: rtl/adder_subtractor_16_bit_reg.sv
// adder_subtractor_16_bit_reg: registered two's-complement add/subtract with carry and overflow flags
module adder_subtractor_16_bit_reg
  import adder_subtractor_16_bit_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int N = WIDTH / 8;
  logic             sub;
  logic [WIDTH-1:0] bx, s;
  logic [N:0]       c;
  logic             ovf;
  assign sub  = subtract == MODE_SUB;
  assign c[0] = sub;
  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    xor x (bx[i], b[i], sub);
  end
  for (genvar k = 0; k < N; k++) begin : g_slice
    adder_subtractor_16_bit_reg_full_adder_8_bit u_fa (
      .sum  (s[8*k +: 8]),
      .cout (c[k+1]),
      .a    (a[8*k +: 8]),
      .b    (bx[8*k +: 8]),
      .cin  (c[k])
    );
  end
  // Overflow uses the conditioned operand so one rule covers both modes
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= s;
      cout     <= c[N];
      overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_adder_subtractor_16_bit_reg.sv
// tb_adder_subtractor_16_bit_reg: directed vector bench for the registered adder/subtractor
module tb_adder_subtractor_16_bit_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        subtract = 1'b0;
  logic [15:0] result;
  logic        cout, overflow;
  int total = 0, bad = 0;

  adder_subtractor_16_bit_reg #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .subtract(subtract),
    .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] res;
    logic        c, o;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vs);
    @(negedge clk);
    a = va;
    b = vb;
    subtract = vs;
  endtask

  task automatic sample;
    @(posedge clk);
    #1;
  endtask

  vec_t v[14];

  initial begin
    v[0]  = '{16'd23,    16'd3,     1'b0, 16'd26,   1'b0, 1'b0};
    v[1]  = '{16'd325,   16'd97,    1'b0, 16'd422,  1'b0, 1'b0};
    v[2]  = '{16'd86,    16'd572,   1'b0, 16'd658,  1'b0, 1'b0};
    v[3]  = '{16'd16800, 16'd16900, 1'b0, 16'h83A4, 1'b0, 1'b1};
    v[4]  = '{16'd23,    16'd3,     1'b1, 16'd20,   1'b1, 1'b0};
    v[5]  = '{16'd6983,  16'd6650,  1'b1, 16'd333,  1'b1, 1'b0};
    v[6]  = '{16'd463,   16'd241,   1'b1, 16'd222,  1'b1, 1'b0};
    v[7]  = '{16'd21,    16'd75,    1'b1, 16'hFFCA, 1'b0, 1'b0};
    v[8]  = '{16'd16800, 16'd16900, 1'b1, 16'hFF9C, 1'b0, 1'b0};
    v[9]  = '{16'd44,    16'd190,   1'b1, 16'hFF6E, 1'b0, 1'b0};
    v[10] = '{16'hFFFF,  16'h0001,  1'b0, 16'h0000, 1'b1, 1'b0};
    v[11] = '{16'h0000,  16'h0001,  1'b1, 16'hFFFF, 1'b0, 1'b0};
    v[12] = '{16'h8000,  16'h0001,  1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[13] = '{16'h7FFF,  16'h0001,  1'b0, 16'h8000, 1'b0, 1'b1};

    // two reset cycles, outputs must be zero
    drive(16'd23, 16'd3, 1'b0);
    sample;
    sample;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].sub);
      sample;
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(v[i].res));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(v[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(v[i].o));
    end

    // reset while an operation is presented: it must be discarded
    drive(16'h8000, 16'h0001, 1'b1);
    sample;
    chk("pre_rst_result", 32'(result), 32'h7FFF);
    @(negedge clk);
    reset = 1'b1;
    a = 16'd23;
    b = 16'd3;
    subtract = 1'b0;
    sample;
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_cout", 32'(cout), 32'h0);
    chk("midrst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    a = 16'd6983;
    b = 16'd6650;
    subtract = 1'b1;
    sample;
    chk("postrst_result", 32'(result), 32'd333);
    chk("postrst_cout", 32'(cout), 32'h1);

    // back-to-back stream with mode alternating every cycle
    for (int k = 0; k < 10; k++) begin
      logic [15:0] ta, tb, er;
      logic        ts, ec;
      ta = 16'(1000 + 777 * k);
      tb = 16'(3000 - 250 * k);
      ts = k[0];
      er = ts ? ta - tb : ta + tb;
      ec = ts ? (ta >= tb) : ((17'(ta) + 17'(tb)) > 17'hFFFF);
      drive(ta, tb, ts);
      sample;
      chk($sformatf("stream%0d_result", k), 32'(result), 32'(er));
      chk($sformatf("stream%0d_cout", k), 32'(cout), 32'(ec));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
